// File: rtl/ps2_keyevent_rx.sv
// ps2_keyevent_rx: PS/2 keyboard receiver with prefix folding and event FIFO.
// The pins are synchronised and 11-bit frames are deframed with an inter-bit
// timeout. E0/F0 prefixes are folded into one {ext, brk, code} event, and
// events are queued in a show-ahead FIFO with a valid/ready interface.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd parity enforced at STOP).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a start bit (fall with data=0)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | checking the stop bit, then handing the byte to decode
module ps2_keyevent_rx #(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_AW     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       frame_err,
  output logic       fifo_ovf
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   fall, data_bit;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          good_q, good_d;
  logic          ferr_q, ferr_d;
  logic          par_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif

  logic          ext_q, ext_d, brk_q, brk_d;
  logic          push;
  logic [9:0]    push_data;

  logic [9:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               pop, full, do_push;

  // Pin synchronisers; reset to the idle-high line level so no false fall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign fall     = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
  assign data_bit = data_sync_q[SYNC_STAGES-2];

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // Deframer state register, timeout counter and decoded-byte handoff
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      byte_q    <= '0;
      good_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      byte_q    <= byte_d;
      good_q    <= good_d;
      ferr_q    <= ferr_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  // Deframer next state: advances only on falls; timeout wins over a fall
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    good_d    = 1'b0;
    ferr_d    = 1'b0;
    tmo_d     = tmo_q + 1'b1;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    if (state_q == ST_IDLE || fall) begin
      tmo_d = '0;
    end
    if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = data_bit;
`endif
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_bit && par_ok) begin
            good_d = 1'b1;
            byte_d = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Prefix flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

  // Prefix folding: E0/F0 arm flags, any other byte emits an event
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push      = 1'b0;
    push_data = {ext_q, brk_q, byte_q};
    if (ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (good_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign pop     = evt_ready & (cnt_q != '0);
  assign full    = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign do_push = push & (~full | pop);

  // FIFO pointer/count next state; a pop frees the slot a full push needs
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = push & full & ~pop;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset because the head is gated by valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign evt_valid = (cnt_q != '0);
  assign {evt_ext, evt_break, evt_code} = evt_valid ? mem_q[rd_ptr_q] : 10'd0;
  assign frame_err = ferr_q;
  assign fifo_ovf  = ovf_q;

endmodule
